// File: rtl/cpu_timing_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpu_timing_pkg
// Description : Shared timing constants and state encodings for the M-cycle
//               sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_timing_pkg;

  localparam int STEPS      = 4;
  localparam int MAX_CYCLES = 8;

  localparam logic [3:0] STEP_FIRST  = 4'b0001;
  localparam logic [7:0] COUNT_FIRST = 8'h01;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/one_hot_ring.sv
//------------------------------------------------------------------------------
// Module      : one_hot_ring
// Description : One-hot rotate-left ring with synchronous load and advance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module one_hot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] C_FIRST = {{(WIDTH-1){1'b0}}, 1'b1};

  // Load wins over advance so a restart on the wrap edge is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= C_FIRST;
    end else if (load) begin
      value <= load_value;
    end else if (advance) begin
      value <= {value[WIDTH-2:0], value[WIDTH-1]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/m_cycle_sequencer.sv
//------------------------------------------------------------------------------
// Module      : m_cycle_sequencer
// Description : One-hot T-step / M-cycle timing generator with stall, HALT/wake
//               and microcode overrun detection.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module m_cycle_sequencer
  import cpu_timing_pkg::*;
#(
  parameter int STEPS      = cpu_timing_pkg::STEPS,
  parameter int MAX_CYCLES = cpu_timing_pkg::MAX_CYCLES
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Clock_Enable,
  input  logic                  i_Stall,
  input  logic                  i_IR_Fetch,
  input  logic                  i_Halt,
  input  logic                  i_Interrupt_Pending,
  output logic [STEPS-1:0]      o_Cycle_Step,
  output logic [MAX_CYCLES-1:0] o_Cycle_Count,
  output logic                  o_M_Cycle_End,
  output logic                  o_Halted,
  output logic                  o_Overrun
);

  localparam logic [MAX_CYCLES-1:0] C_COUNT_FIRST = {{(MAX_CYCLES-1){1'b0}}, 1'b1};

  seq_state_t              state;
  seq_state_t              state_next;
  logic [STEPS-1:0]        step;
  logic [MAX_CYCLES-1:0]   count;
  logic                    advance;
  logic                    m_end;
  logic                    fetch_now;
  logic                    halt_now;
  logic                    count_load;
  logic                    count_advance;
  logic                    overrun_next;
  logic                    fetch_latch;
  logic                    halt_latch;
  logic                    overrun;

  assign advance   = i_Clock_Enable & ~i_Stall & (state == ST_RUN);
  assign m_end     = advance & step[STEPS-1];
  assign fetch_now = fetch_latch | i_IR_Fetch;
  assign halt_now  = halt_latch | i_Halt;

  // The step ring wraps 1000 -> 0001 by rotation, so HALTED always holds 0001.
  one_hot_ring #(
    .WIDTH      (STEPS)
  ) u_step_ring (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .load       (1'b0),
    .load_value ({STEPS{1'b0}}),
    .advance    (advance),
    .value      (step)
  );

  one_hot_ring #(
    .WIDTH      (MAX_CYCLES)
  ) u_count_ring (
    .clk        (i_Clk),
    .rst        (i_Reset),
    .load       (count_load),
    .load_value (C_COUNT_FIRST),
    .advance    (count_advance),
    .value      (count)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_load    = 1'b0;
    count_advance = 1'b0;
    overrun_next  = 1'b0;
    case (state)
      ST_RUN: begin
        if (m_end) begin
          if (fetch_now && halt_now) begin
            count_load = 1'b1;
            state_next = ST_HALTED;
          end else if (fetch_now) begin
            count_load = 1'b1;
          end else if (count[MAX_CYCLES-1]) begin
            count_load   = 1'b1;
            overrun_next = 1'b1;
          end else begin
            count_advance = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        if (i_Clock_Enable && i_Interrupt_Pending) begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // Fetch/halt requests may arrive on any T-step; they are held until the M-cycle closes.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      fetch_latch <= 1'b0;
      halt_latch  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      overrun <= overrun_next;
      if (m_end) begin
        fetch_latch <= 1'b0;
        halt_latch  <= 1'b0;
      end else if ((state == ST_RUN) && i_IR_Fetch) begin
        fetch_latch <= 1'b1;
        if (i_Halt) begin
          halt_latch <= 1'b1;
        end
      end
    end
  end

  assign o_Cycle_Step  = (state == ST_HALTED) ? {STEPS{1'b0}} : step;
  assign o_Cycle_Count = count;
  assign o_M_Cycle_End = m_end;
  assign o_Halted      = (state == ST_HALTED);
  assign o_Overrun     = overrun;

endmodule

`default_nettype wire

// File: tb/tb_m_cycle_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_m_cycle_sequencer
// Description : Directed self-checking bench for m_cycle_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_m_cycle_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic       stall;
  logic       fetch;
  logic       halt;
  logic       pending;
  logic [3:0] step;
  logic [7:0] count;
  logic       m_end;
  logic       halted;
  logic       overrun;

  int checks;
  int errors;

  m_cycle_sequencer dut (
    .i_Clk               (clk),
    .i_Reset             (rst),
    .i_Clock_Enable      (en),
    .i_Stall             (stall),
    .i_IR_Fetch          (fetch),
    .i_Halt              (halt),
    .i_Interrupt_Pending (pending),
    .o_Cycle_Step        (step),
    .o_Cycle_Count       (count),
    .o_M_Cycle_End       (m_end),
    .o_Halted            (halted),
    .o_Overrun           (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] s, input logic [7:0] c,
                           input logic h);
    chk({tag, "_step"}, {28'd0, step}, {28'd0, s});
    chk({tag, "_count"}, {24'd0, count}, {24'd0, c});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, h});
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    en      = 1'b0;
    stall   = 1'b0;
    fetch   = 1'b0;
    halt    = 1'b0;
    pending = 1'b0;
    tick(2);
    chk_state("reset", 4'b0001, 8'h01, 1'b0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_mend", {31'd0, m_end}, 32'd0);
    rst = 1'b0;

    // Free run: four M-cycles, end strobe on every fourth enabled clock.
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("run_step", {28'd0, step}, 32'd1 << (i % 4));
      chk("run_count", {24'd0, count}, 32'd1 << (i / 4));
      chk("run_mend", {31'd0, m_end}, (i % 4 == 3) ? 32'd1 : 32'd0);
      tick(1);
    end
    chk_state("run_done", 4'b0001, 8'h10, 1'b0);

    // Fifth M-cycle carries an IR fetch on step 0100.
    tick(2);
    chk_state("fetch_pre", 4'b0100, 8'h10, 1'b0);
    fetch = 1'b1;
    tick(1);
    fetch = 1'b0;
    chk("fetch_last_mend", {31'd0, m_end}, 32'd1);
    tick(1);
    chk_state("fetch_restart", 4'b0001, 8'h01, 1'b0);
    tick(4);
    chk_state("fetch_next", 4'b0001, 8'h02, 1'b0);

    // Stall at step 0010, count 04.
    tick(5);
    chk_state("stall_pre", 4'b0010, 8'h04, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_state("stall_hold", 4'b0010, 8'h04, 1'b0);
      chk("stall_mend", {31'd0, m_end}, 32'd0);
    end
    stall = 1'b0;
    tick(1);
    chk_state("stall_resume", 4'b0100, 8'h04, 1'b0);
    en = 1'b0;
    tick(1);
    chk_state("enable_low", 4'b0100, 8'h04, 1'b0);
    en = 1'b1;
    tick(1);
    stall = 1'b1;
    #1;
    chk("stall_last_mend", {31'd0, m_end}, 32'd0);
    tick(1);
    chk_state("stall_last_hold", 4'b1000, 8'h04, 1'b0);
    stall = 1'b0;
    #1;
    chk("stall_last_release", {31'd0, m_end}, 32'd1);
    tick(1);
    chk_state("stall_cycle_end", 4'b0001, 8'h08, 1'b0);

    // Restart the count, then HALT with no interrupt pending.
    fetch = 1'b1;
    tick(1);
    fetch = 1'b0;
    tick(3);
    chk_state("pre_halt", 4'b0001, 8'h01, 1'b0);
    fetch = 1'b1;
    halt  = 1'b1;
    tick(1);
    fetch = 1'b0;
    halt  = 1'b0;
    tick(3);
    chk_state("halt_entry", 4'b0000, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stall = (i >= 4 && i < 7);
      tick(1);
      chk_state("halt_hold", 4'b0000, 8'h01, 1'b1);
    end
    stall   = 1'b0;
    pending = 1'b1;
    tick(1);
    chk_state("halt_wake", 4'b0001, 8'h01, 1'b0);
    pending = 1'b0;

    // HALT completing with the interrupt already pending: one HALTED clock.
    tick(3);
    fetch   = 1'b1;
    halt    = 1'b1;
    pending = 1'b1;
    #1;
    chk("halt_fast_mend", {31'd0, m_end}, 32'd1);
    tick(1);
    fetch = 1'b0;
    halt  = 1'b0;
    chk_state("halt_fast_in", 4'b0000, 8'h01, 1'b1);
    tick(1);
    chk_state("halt_fast_out", 4'b0001, 8'h01, 1'b0);
    pending = 1'b0;

    // Eight M-cycles without fetch wrap the count and pulse overrun.
    tick(28);
    chk_state("ovr_pre", 4'b0001, 8'h80, 1'b0);
    tick(3);
    chk("ovr_low", {31'd0, overrun}, 32'd0);
    tick(1);
    chk_state("ovr_wrap", 4'b0001, 8'h01, 1'b0);
    chk("ovr_pulse", {31'd0, overrun}, 32'd1);
    tick(1);
    chk("ovr_single", {31'd0, overrun}, 32'd0);
    chk_state("ovr_after", 4'b0010, 8'h01, 1'b0);

    // Reset mid-M-cycle at step 0100, count 08.
    tick(11);
    chk_state("rst_mid_pre", 4'b0001, 8'h08, 1'b0);
    tick(2);
    chk_state("rst_mid_at", 4'b0100, 8'h08, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_state("rst_mid", 4'b0001, 8'h01, 1'b0);
    chk("rst_mid_overrun", {31'd0, overrun}, 32'd0);

    // Reset while HALTED.
    fetch = 1'b1;
    halt  = 1'b1;
    tick(1);
    fetch = 1'b0;
    halt  = 1'b0;
    tick(3);
    chk_state("rst_halt_pre", 4'b0000, 8'h01, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_state("rst_halt", 4'b0001, 8'h01, 1'b0);
    chk("rst_halt_overrun", {31'd0, overrun}, 32'd0);
    tick(1);
    chk_state("rst_halt_run", 4'b0010, 8'h01, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/m_cycle_sequencer.md
Name: m_cycle_sequencer

Overview:
- Generates the one-hot T-step (`o_Cycle_Step`) and one-hot M-cycle (`o_Cycle_Count`) timing vectors consumed by every per-opcode microcode block in the control unit.
- Sits directly upstream of the microcode ROM/decoder fan-out.
- Restarts the M-cycle count when microcode raises IR fetch.
- Freezes on memory stall; implements HALT/wake and overrun detection.

Parameters:
- STEPS, 4, T-steps per M-cycle (width of `o_Cycle_Step`)
- MAX_CYCLES, 8, maximum M-cycles per instruction (width of `o_Cycle_Count`)

Ports:
- i_Clk  input  1  CPU clock
- i_Reset  input  1  synchronous, active-high reset
- i_Clock_Enable  input  1  T-step advance strobe (one per T-state)
- i_Stall  input  1  memory/bus wait; holds all timing state
- i_IR_Fetch  input  1  OR of all microcode o_IR_Fetch; current M-cycle is the instruction's last
- i_Halt  input  1  HALT opcode decoded; valid while i_IR_Fetch is high
- i_Interrupt_Pending  input  1  any enabled interrupt flagged (IE & IF)
- o_Cycle_Step  output  STEPS  one-hot T-step
- o_Cycle_Count  output  MAX_CYCLES  one-hot M-cycle index within instruction
- o_M_Cycle_End  output  1  last T-step of an M-cycle is advancing this clock
- o_Halted  output  1  sequencer is in HALTED state
- o_Overrun  output  1  one-clock pulse: count wrapped with no IR fetch (microcode bug)

Behaviour:
- Reset (synchronous, i_Reset high at rising i_Clk) has priority over everything:
  - step=0001, count=00000001, state=RUN
  - fetch_latch=0, halt_latch=0
  - o_M_Cycle_End=0, o_Halted=0, o_Overrun=0
- advance = i_Clock_Enable & ~i_Stall & (state==RUN).
- States: RUN, HALTED.
- RUN:
  - On advance with step != step[3]: step rotates left by one; count unchanged.
  - On advance with step[3]: step returns to 0001 and the M-cycle ends.
  - o_M_Cycle_End = step[3] & advance, combinational.
- fetch_latch:
  - Set on any clock in RUN where i_IR_Fetch=1 (stall or not).
  - halt_latch is set on the same condition when i_Halt=1 as well.
  - Both latches clear at M-cycle end.
- At M-cycle end (priority order):
  1. fetch_latch|i_IR_Fetch and halt_latch|i_Halt: count=00000001, state→HALTED.
  2. fetch_latch|i_IR_Fetch: count=00000001 (new instruction begins).
  3. count[MAX_CYCLES-1] set with no fetch: count=00000001, o_Overrun=1 for exactly one clock.
  4. Otherwise: count shifts left by one.
- Stall:
  - i_Stall=1 holds step and count on any step; outputs stay stable.
  - Microcode strobes repeat; this is the defined behaviour downstream depends on.
  - i_Stall deasserting resumes on the next enabled clock.
- HALTED:
  - o_Cycle_Step is forced to 0000, so no microcode acts; o_Cycle_Count=00000001; o_Halted=1.
  - Internal step is held at 0001.
  - Leaves HALTED on the first i_Clock_Enable clock with i_Interrupt_Pending=1: state→RUN, o_Cycle_Step=0001 on the following clock.
  - i_Interrupt_Pending already high when HALT completes: exactly one HALTED clock, then resume (no skip of HALTED state).
  - i_Stall is ignored while HALTED.
- Reset mid-M-cycle, during stall, or during HALTED: immediate return to reset values on that clock.
- Outputs `o_Cycle_Step` and `o_Cycle_Count` are registered; exactly one bit is set except `o_Cycle_Step`=0000 while HALTED.
- i_Clock_Enable low: no state change; o_M_Cycle_End=0.
- Latency: i_IR_Fetch seen in M-cycle k → `o_Cycle_Count`=00000001 on the step[0] of M-cycle k+1.

Decomposition:
- Shared constants header/package (cpu_timing_pkg):
  - STEPS, MAX_CYCLES
  - STEP_FIRST=4'b0001, COUNT_FIRST=8'h01
  - state encodings ST_RUN, ST_HALTED
- One natural sub-module: one_hot_ring (width parameter, load, load value, advance), instantiated twice: step ring and count ring.
- Control FSM and latches stay in m_cycle_sequencer.

Test Plan:
- Reset then 16 enabled clocks, i_IR_Fetch low → step cycles 0001→0010→0100→1000 four times; count 01→02→04→08→10; o_M_Cycle_End high on clocks 4, 8, 12, 16.
- 5-cycle instruction (i_IR_Fetch pulsed one clock during count=10, step=0100) → after that step=1000 advance, count=01; fetch_latch cleared; next M-cycle count=02.
- i_Stall high 3 clocks at step=0010, count=04 → outputs frozen 3 clocks, o_M_Cycle_End=0; resume to step=0100 on the next enable.
- i_IR_Fetch+i_Halt at count=01, i_Interrupt_Pending low 10 clocks then high → o_Halted=1, o_Cycle_Step=0000 throughout; one clock after pending, o_Halted=0, step=0001, count=01.
- 8 M-cycles with no fetch → on count=80 step=1000 advance: count=01, o_Overrun=1 for one clock only.
- i_Reset asserted at step=0100, count=08 and again while HALTED → next clock step=0001, count=01, o_Halted=0, o_Overrun=0.
